// File: rtl/port_ingress_buffer.sv
// Per-port ingress packet FIFO feeding the write arbiter.
// Words are stored as {sop, eop, data}. Only fully received (committed) packets
// are visible to the reader; a packet that overflows the buffer or is cut short
// by a new sop is rolled back to the last commit point and never presented.
//
// Handshake: the source pushes one word per cycle with in_vld (no ready; the
// registered in_almost_full is advisory only). The arbiter requests one word per
// cycle with next_data; a request is honoured only when committed data exists,
// and the word appears one cycle later with vld=1 (vld is 0 otherwise).
module port_ingress_buffer #(
    parameter int DATA_WIDTH = 256,
    parameter int PTR_WIDTH  = 6,
    parameter int AF_LEVEL   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_almost_full,
    output logic                  ready,
    input  logic                  next_data,
    output logic                  vld,
    output logic                  sop,
    output logic                  eop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  drop_pulse,
    output logic [PTR_WIDTH:0]    pkt_cnt,
    output logic [1:0]            wr_state_dbg
);

    localparam int                 DEPTH   = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_P = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_P    = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] ONE_P   = (PTR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } wr_state_e;

    logic [DATA_WIDTH+1:0] mem [DEPTH];

    wr_state_e             state_q, state_d;
    logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]    commit_ptr_q, commit_ptr_d;
    logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]    pkt_cnt_q, pkt_cnt_d;
    logic                  vld_q, vld_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  drop_q, drop_d;
    logic                  af_q, af_d;

    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_addr;
    logic [PTR_WIDTH:0]    wr_base;
    logic                  full;
    logic                  commit_evt;
    logic                  pop;
    logic                  pop_eop;
    logic [DATA_WIDTH+1:0] rd_word;
    logic [PTR_WIDTH:0]    free_d;

    // Write FSM: accept, commit, or roll back incoming words.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_d       = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q[PTR_WIDTH-1:0];
        commit_evt   = 1'b0;
        wr_base      = wr_ptr_q;
        // A sop arriving mid-packet truncates it: roll back first, then treat
        // the sop word as a fresh packet against the rolled-back pointer.
        if (state_q == S_RECV && in_vld && in_sop) begin
            wr_base  = commit_ptr_q;
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
        end
        // Fullness is judged against the pre-pop read pointer: a pop this
        // cycle only frees space from the next cycle onward.
        full = ((wr_base - rd_ptr_q) == DEPTH_P);
        if (in_vld) begin
            if (in_sop) begin
                if (!full) begin
                    wr_en    = 1'b1;
                    wr_addr  = wr_base[PTR_WIDTH-1:0];
                    wr_ptr_d = wr_base + ONE_P;
                    if (in_eop) begin
                        commit_ptr_d = wr_base + ONE_P;
                        commit_evt   = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_RECV;
                    end
                end else begin
                    drop_d  = 1'b1;
                    state_d = in_eop ? S_IDLE : S_DROP;
                end
            end else if (state_q == S_RECV) begin
                if (!full) begin
                    wr_en    = 1'b1;
                    wr_addr  = wr_ptr_q[PTR_WIDTH-1:0];
                    wr_ptr_d = wr_ptr_q + ONE_P;
                    if (in_eop) begin
                        commit_ptr_d = wr_ptr_q + ONE_P;
                        commit_evt   = 1'b1;
                        state_d      = S_IDLE;
                    end
                end else begin
                    wr_ptr_d = commit_ptr_q;
                    drop_d   = 1'b1;
                    state_d  = in_eop ? S_IDLE : S_DROP;
                end
            end else if (state_q == S_DROP && in_eop) begin
                state_d = S_IDLE;
            end
        end
    end

    // Read side, packet count and advisory almost-full.
    always_comb begin
        rd_word  = mem[rd_ptr_q[PTR_WIDTH-1:0]];
        pop      = next_data && (rd_ptr_q != commit_ptr_q);
        pop_eop  = pop && rd_word[DATA_WIDTH];
        rd_ptr_d = pop ? (rd_ptr_q + ONE_P) : rd_ptr_q;
        vld_d    = pop;
        sop_d    = pop && rd_word[DATA_WIDTH+1];
        eop_d    = pop_eop;
        data_d   = pop ? rd_word[DATA_WIDTH-1:0] : data_q;
        case ({commit_evt, pop_eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + ONE_P;
            2'b01:   pkt_cnt_d = pkt_cnt_q - ONE_P;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        free_d = DEPTH_P - (wr_ptr_d - rd_ptr_d);
        af_d   = (free_d <= AF_P);
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {in_sop, in_eop, in_data};
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            vld_q        <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            data_q       <= '0;
            drop_q       <= 1'b0;
            af_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            vld_q        <= vld_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            data_q       <= data_d;
            drop_q       <= drop_d;
            af_q         <= af_d;
        end
    end

    assign in_almost_full = af_q;
    assign ready          = (pkt_cnt_q != '0);
    assign vld            = vld_q;
    assign sop            = sop_q;
    assign eop            = eop_q;
    assign data_out       = data_q;
    assign drop_pulse     = drop_q;
    assign pkt_cnt        = pkt_cnt_q;
    assign wr_state_dbg   = state_q;

endmodule

// File: tb/tb_port_ingress_buffer.sv
// Self-checking bench for port_ingress_buffer: directed scenarios plus random
// traffic, compared against a packet-level reference model (queues of words).
module tb_port_ingress_buffer;

    localparam int DW    = 256;
    localparam int PW    = 6;
    localparam int DEPTH = 64;
    localparam int AF    = 8;

    typedef logic [DW+1:0] word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          next_data = 1'b0;
    logic          in_almost_full, ready, vld, sop, eop, drop_pulse;
    logic [DW-1:0] data_out;
    logic [PW:0]   pkt_cnt;
    logic [1:0]    wr_state_dbg;

    // Reference model: committed words awaiting readout, the packet being received.
    word_t         cq[$];
    word_t         pend[$];
    logic [DW+1:0] exp_q[$];
    bit            in_pkt;
    int            exp_cnt;
    bit            exp_drop, exp_af, exp_vld;
    logic [DW-1:0] last_data;
    bit            mon_en = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    port_ingress_buffer #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .in_almost_full(in_almost_full), .ready(ready), .next_data(next_data),
        .vld(vld), .sop(sop), .eop(eop), .data_out(data_out),
        .drop_pulse(drop_pulse), .pkt_cnt(pkt_cnt), .wr_state_dbg(wr_state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int count_pkts();
        int n = 0;
        foreach (cq[i]) if (cq[i][DW]) n++;
        return n;
    endfunction

    // One clock of stimulus; the model predicts the state after the next rising edge.
    task automatic cycle(input bit v, input bit s, input bit e, input bit nd);
        word_t w;
        int    used;
        @(negedge clk);
        w         = {s, e, rand_data()};
        in_vld    = v;
        in_sop    = s;
        in_eop    = e;
        in_data   = w[DW-1:0];
        next_data = nd;
        used      = cq.size() + pend.size();
        exp_vld   = 1'b0;
        exp_drop  = 1'b0;
        if (nd && cq.size() > 0) begin
            exp_q.push_back(cq.pop_front());
            exp_vld = 1'b1;
        end
        if (v) begin
            if (s) begin
                if (in_pkt) begin
                    used -= pend.size();
                    pend.delete();
                    exp_drop = 1'b1;
                end
                in_pkt = 1'b0;
                if (used < DEPTH) begin
                    pend.push_back(w);
                    if (e) while (pend.size() > 0) cq.push_back(pend.pop_front());
                    else in_pkt = 1'b1;
                end else begin
                    exp_drop = 1'b1;
                end
            end else if (in_pkt) begin
                if (used < DEPTH) begin
                    pend.push_back(w);
                    if (e) begin
                        while (pend.size() > 0) cq.push_back(pend.pop_front());
                        in_pkt = 1'b0;
                    end
                end else begin
                    pend.delete();
                    exp_drop = 1'b1;
                    in_pkt   = 1'b0;
                end
            end
        end
        exp_af  = (DEPTH - (cq.size() + pend.size())) <= AF;
        exp_cnt = count_pkts();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; next_data = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ready", DW'(ready), '0);
        chk("rst_vld", DW'(vld), '0);
        chk("rst_pkt_cnt", DW'(pkt_cnt), '0);
        chk("rst_sop_eop", DW'({sop, eop}), '0);
        chk("rst_drop", DW'(drop_pulse), '0);
        chk("rst_af", DW'(in_almost_full), '0);
        chk("rst_data", data_out, '0);
        cq.delete(); pend.delete(); exp_q.delete();
        in_pkt = 1'b0; exp_cnt = 0; exp_drop = 1'b0; exp_af = 1'b0; exp_vld = 1'b0;
        last_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && cq.size() > 0; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor / scoreboard: compares outputs just after every rising edge.
    initial begin
        word_t w;
        forever begin
            @(posedge clk);
            #1;
            if (rst && mon_en) begin
                chk("pkt_cnt", DW'(pkt_cnt), DW'(exp_cnt));
                chk("ready", DW'(ready), DW'(exp_cnt != 0));
                chk("drop_pulse", DW'(drop_pulse), DW'(exp_drop));
                chk("almost_full", DW'(in_almost_full), DW'(exp_af));
                chk("vld", DW'(vld), DW'(exp_vld));
                if (vld) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: vld=1 with nothing expected, data %h", data_out);
                    end else begin
                        w = exp_q.pop_front();
                        chk("data_out", data_out, w[DW-1:0]);
                        chk("sop", DW'(sop), DW'(w[DW+1]));
                        chk("eop", DW'(eop), DW'(w[DW]));
                        last_data = w[DW-1:0];
                    end
                end else begin
                    chk("idle_sop_eop", DW'({sop, eop}), '0);
                    chk("idle_data_hold", data_out, last_data);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int pop_pct;
        do_reset();

        // 3-word packet, then three pops
        cycle(1, 1, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 1);
        drain();

        // single-word packet, next_data held for two cycles
        cycle(1, 1, 1, 0);
        cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
        drain();

        // 60-word committed packet, then a 10-word packet that overflows
        cycle(1, 1, 0, 0);
        repeat (58) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 1, 0, 0);
        repeat (8) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        drain();

        // truncation by a new sop
        cycle(1, 1, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 1, 0);
        drain();

        // commit and pop of an eop in the same cycle
        cycle(1, 1, 1, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 1);
        drain();

        // reset mid-packet with two committed packets held
        cycle(1, 1, 1, 0); cycle(1, 1, 1, 0);
        cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
        do_reset();
        cycle(1, 1, 1, 0);
        cycle(0, 0, 0, 1);
        drain();

        // random traffic with alternating drain pressure
        pop_pct = 10;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) pop_pct = (pop_pct == 10) ? 90 : 10;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 99) < pop_pct);
        end
        drain();
        chk("exp_q_empty", DW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
